// File: rtl/comparator.sv
// Registered 32-bit compare unit: val1 - val2 captured as N,Z,C,V flags.
// Flags load on clock edges with is_cmp_op high and hold otherwise.
module comparator (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic        is_cmp_op,
  output logic [3:0]  nzcv
);

  logic [32:0] diff;
  logic [31:0] res;
  logic        n_flag;
  logic        z_flag;
  logic        c_flag;
  logic        v_flag;
  logic [3:0]  nzcv_d;
  logic [3:0]  nzcv_q;

  // Subtract as add of the inverted subtrahend; bit 32 is the no-borrow carry.
  assign diff = {1'b0, val1} + {1'b0, ~val2} + 33'd1;
  assign res  = diff[31:0];

  assign n_flag = res[31];
  assign z_flag = (res == 32'd0);
  assign c_flag = diff[32];
  assign v_flag = (val1[31] != val2[31]) && (res[31] != val1[31]);

  always_comb begin
    nzcv_d = nzcv_q;
    if (is_cmp_op) begin
      nzcv_d = {n_flag, z_flag, c_flag, v_flag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign nzcv = nzcv_q;

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed vectors plus an
// arithmetic reference model checked on every falling clock edge.
module tb_comparator;

  logic        clk;
  logic        rst;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        is_cmp_op;
  logic [3:0]  nzcv;

  int tests;
  int fails;
  logic [3:0] exp_q;
  logic       done;

  comparator dut (
    .clk       (clk),
    .rst       (rst),
    .val1      (val1),
    .val2      (val2),
    .is_cmp_op (is_cmp_op),
    .nzcv      (nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference flags from plain signed/unsigned arithmetic
  function automatic logic [3:0] ref_flags(input logic [31:0] a,
                                           input logic [31:0] b);
    longint     sd;
    logic [31:0] r;
    logic       n, z, c, v;
    sd = longint'($signed(a)) - longint'($signed(b));
    r  = a - b;
    n  = r[31];
    z  = (r == 32'd0);
    c  = (a >= b);
    v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {n, z, c, v};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)
      exp_q <= 4'b0000;
    else if (is_cmp_op)
      exp_q <= ref_flags(val1, val2);
  end

  always @(negedge clk) begin
    if (!done) begin
      tests++;
      if (nzcv !== exp_q) begin
        fails++;
        $display("FAIL model t=%0t nzcv=%h expected=%h", $time, nzcv, exp_q);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] want);
    tests++;
    if (nzcv !== want) begin
      fails++;
      $display("FAIL %s nzcv=%h expected=%h", name, nzcv, want);
    end
  endtask

  task automatic cmp(input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] want);
    val1 = a;
    val2 = b;
    is_cmp_op = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("cmp %h-%h", a, b), want);
  endtask

  logic [31:0] ops [4];
  logic [3:0]  tbl [16];

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;
    ops[0] = 32'h0000_0000;
    ops[1] = 32'h7fff_ffff;
    ops[2] = 32'h8000_0000;
    ops[3] = 32'hffff_ffff;
    tbl = '{4'h6, 4'h8, 4'h9, 4'h0,
            4'h2, 4'h6, 4'h9, 4'h9,
            4'hA, 4'h3, 4'h6, 4'h8,
            4'hA, 4'hA, 4'h2, 4'h6};

    rst = 1'b0;
    val1 = 32'h8000_0000;
    val2 = 32'h0000_0001;
    is_cmp_op = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 4'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_idle", 4'h0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        cmp(ops[i], ops[j], tbl[i*4+j]);

    cmp(32'd5, 32'd3, 4'h2);
    cmp(32'd3, 32'd5, 4'h8);

    cmp(32'h8000_0000, 32'h7fff_ffff, 4'h3);
    is_cmp_op = 1'b0;
    val1 = 32'd0;
    val2 = 32'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d", k), 4'h3);
    end
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_hold", 4'h0);
    @(negedge clk);
    rst = 1'b0;

    cmp(32'hffff_ffff, 32'd0, 4'hA);
    rst = 1'b1;
    is_cmp_op = 1'b1;
    val1 = 32'd0;
    val2 = 32'd0;
    @(posedge clk);
    #1;
    check("reset_wins", 4'h0);
    @(negedge clk);
    rst = 1'b0;
    is_cmp_op = 1'b0;

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      val1 = $urandom;
      val2 = (k % 5 == 0) ? val1 : $urandom;
      is_cmp_op = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    is_cmp_op = 1'b0;
    @(negedge clk);
    done = 1'b1;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
